// File: rtl/rr_arb_four.sv
// rr_arb_four: four-way round-robin arbiter with a bounded hold time.
//
// A grant is issued from IDLE one cycle after a request is seen. The search
// starts one position after the most recent holder, so every requester gets
// a turn. The holder keeps the grant until it pulses done, drops its request,
// or reaches MAX_HOLD cycles. Reaching MAX_HOLD cycles without done and
// without the request dropping is a forced release, flagged by timeout. At
// least one IDLE cycle separates consecutive grants.
//
// Ports:
//   clk     - sole clock, all state changes on the rising edge
//   rst     - synchronous, active-high reset
//   req     - request vector, bit i belongs to requester i
//   done    - release pulse from the current holder (ignored in IDLE)
//   gnt     - one-hot grant, all-zero when nobody holds the grant
//   gnt_id  - binary index of the current or most recent holder
//   busy    - high while a grant is active
//   timeout - one-cycle pulse after a forced release
module rr_arb_four #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value on the last cycle a grant may be held.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_r, state_s;
  logic [1:0] last_r, last_s;
  logic [1:0] gnt_id_r, gnt_id_s;
  logic [3:0] gnt_r, gnt_s;
  logic       busy_r, busy_s;
  logic       timeout_r, timeout_s;
  logic [7:0] cnt_r, cnt_s;
  logic [2:0] pick_s;
  logic       holder_req_s;
  logic       limit_s;

  // 2-to-4 one-hot decode of a requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Rotating priority search: returns {found, index}, scanning last+1,
  // last+2, last+3 and finally last itself.
  function automatic logic [2:0] pick_next(input logic [3:0] r, input logic [1:0] last);
    logic       found;
    logic [1:0] sel;
    logic [1:0] cand;
    found = 1'b0;
    sel   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

  assign pick_s       = pick_next(req, last_r);
  assign holder_req_s = req[gnt_id_r];
  assign limit_s      = (cnt_r == HOLD_LIMIT);

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    gnt_id_s  = gnt_id_r;
    gnt_s     = gnt_r;
    busy_s    = busy_r;
    timeout_s = 1'b0;
    cnt_s     = cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_s  = GRANT;
          gnt_id_s = pick_s[1:0];
          gnt_s    = onehot4(pick_s[1:0]);
          busy_s   = 1'b1;
          cnt_s    = 8'd0;
        end else begin
          gnt_s  = 4'b0000;
          busy_s = 1'b0;
        end
      end
      GRANT: begin
        if (done || !holder_req_s || limit_s) begin
          state_s   = IDLE;
          gnt_s     = 4'b0000;
          busy_s    = 1'b0;
          last_s    = gnt_id_r;
          // Forced release only when nothing else explains the release.
          timeout_s = limit_s && !done && holder_req_s;
        end else begin
          gnt_s  = onehot4(gnt_id_r);
          busy_s = 1'b1;
          cnt_s  = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        busy_s  = 1'b0;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      last_r    <= 2'b11;
      gnt_id_r  <= 2'b00;
      gnt_r     <= 4'b0000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      gnt_id_r  <= gnt_id_s;
      gnt_r     <= gnt_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
      cnt_r     <= cnt_s;
    end
  end

endmodule

// File: tb/tb_rr_arb_four.sv
module tb_rr_arb_four;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who holds the grant, for how many cycles, who was last.
  bit m_granted;
  int m_holder;
  int m_cnt;
  int m_last;
  bit m_timeout;

  rr_arb_four #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_gnt();
    if (m_granted) return 4'(1 << m_holder);
    else return 4'b0000;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns later.
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    bit lim;
    req = r; done = d; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_granted = 1'b0; m_holder = 0; m_cnt = 0; m_last = 3; m_timeout = 1'b0;
    end else if (!m_granted) begin
      m_timeout = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_granted && r[(m_last + k) % 4]) begin
          m_granted = 1'b1;
          m_holder  = (m_last + k) % 4;
          m_cnt     = 0;
        end
      end
    end else begin
      lim = (m_cnt == MAX_HOLD - 1);
      if (d || !r[m_holder] || lim) begin
        m_granted = 1'b0;
        m_last    = m_holder;
        m_timeout = lim && !d && r[m_holder];
      end else begin
        m_cnt++;
        m_timeout = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
      n_bad++;
      $display("FAIL reset: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seen[$];
    logic [3:0] exp_seq [5];
    logic [3:0] prev;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    test_reset();
    prev = 4'b0000;
    for (int c = 0; c < 24; c++) begin
      step(4'b1111, m_granted && (m_cnt == 2), 1'b0);
      if (gnt !== 4'b0000 && prev === 4'b0000) seen.push_back(gnt);
      if (gnt !== 4'b0000 && prev !== 4'b0000 && gnt !== prev) begin
        n_cmp++; n_bad++;
        $display("FAIL rotation_gap: gnt %b followed %b with no idle cycle", gnt, prev);
      end
      prev = gnt;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= seen.size() || seen[i] !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL rotation[%0d]: got %b, want %b", i, (i < seen.size()) ? seen[i] : 4'bxxxx, exp_seq[i]);
      end
    end
  endtask

  task automatic test_done_release();
    test_reset();
    step(4'b0100, 1'b0, 1'b0);
    n_cmp++;
    if ({gnt, gnt_id, busy} !== 7'b0100_10_1) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
    end
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_10_0_0) begin
      n_bad++;
      $display("FAIL done_release: got gnt=%b id=%0d busy=%b to=%b, want 0000/2/0/0", gnt, gnt_id, busy, timeout);
    end
    // last is now 2, so requester 3 is first in line.
    step(4'b1111, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++;
      $display("FAIL last_after_done: got gnt=%b, want 1000", gnt);
    end
  endtask

  task automatic test_timeout();
    int held;
    bit seen_to;
    test_reset();
    held = 0;
    seen_to = 1'b0;
    for (int c = 0; c < 20 && !seen_to; c++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (gnt === 4'b0001) held++;
      if (timeout === 1'b1) begin
        seen_to = 1'b1;
        n_cmp++;
        if (gnt !== 4'b0000 || held != MAX_HOLD) begin
          n_bad++;
          $display("FAIL timeout: held %0d cycles gnt=%b, want %0d cycles gnt=0000", held, gnt, MAX_HOLD);
        end
      end
    end
    if (!seen_to) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_missing: no timeout pulse within 20 cycles, want one after %0d", MAX_HOLD);
    end
    step(4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_width: got timeout=%b, want 0", timeout);
    end
  endtask

  task automatic test_req_drop();
    test_reset();
    step(4'b1000, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_bad++;
      $display("FAIL grant3: got gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
    end
    step(4'b0011, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL req_drop: got gnt=%b to=%b, want 0000/0", gnt, timeout);
    end
    step(4'b0011, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL wrap_to_0: got gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_reset_in_grant();
    test_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1100, 1'b0, 1'b1);
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
      n_bad++;
      $display("FAIL reset_in_grant: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
    end
    step(4'b1100, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL after_reset_grant: got gnt=%b, want 0100", gnt);
    end
  endtask

  task automatic test_done_at_limit();
    test_reset();
    for (int c = 0; c < MAX_HOLD; c++) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL done_at_limit: got gnt=%b to=%b, want 0000/0", gnt, timeout);
    end
    // done while idle must not disturb anything.
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b1, 1'b0);
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
        n_bad++;
        $display("FAIL done_in_idle: got gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt, gnt_id, busy, timeout);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic d, rs;
    test_reset();
    for (int c = 0; c < 600; c++) begin
      r  = 4'($urandom_range(0, 15));
      // Keep the holder's request up most of the time so timeouts happen.
      if (m_granted && $urandom_range(0, 9) != 0) r[m_holder] = 1'b1;
      d  = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(r, d, rs);
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt(), 2'(m_holder), m_granted, m_timeout}) begin
        n_bad++;
        $display("FAIL random[%0d]: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                 c, gnt, gnt_id, busy, timeout, m_gnt(), m_holder, m_granted, m_timeout);
      end
      n_cmp++;
      if ($countones(gnt) > 1) begin
        n_bad++;
        $display("FAIL onehot[%0d]: got gnt=%b, want at most one bit", c, gnt);
      end
    end
  endtask

  initial begin
    req = 4'b0000; done = 1'b0; rst = 1'b1;
    m_granted = 1'b0; m_holder = 0; m_cnt = 0; m_last = 3; m_timeout = 1'b0;
    test_reset();
    test_rotation();
    test_done_release();
    test_timeout();
    test_req_drop();
    test_reset_in_grant();
    test_done_at_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_four.md
RR_ARB_FOUR -- requirements
Module: rr_arb_four

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum cycles one grant may be held (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req, input, 4, request per requester; bit i = requester i.
REQ-005 SHALL have port done, input, 1, release pulse from current grant holder.
REQ-006 SHALL have port gnt, output, 4, one-hot grant; all-zero when none.
REQ-007 SHALL have port gnt_id, output, 2, binary index of current/last grant holder.
REQ-008 SHALL have port busy, output, 1, high while a grant is active.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE and GRANT; all outputs registered.
REQ-011 SHALL keep a 2-bit pointer last, holding the most recently granted index.
REQ-012 In IDLE with req != 0, SHALL select the first set bit in the order last+1, last+2, last+3, last (mod 4), load it into gnt_id, and enter GRANT.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE; gnt, busy stay 0; gnt_id holds.
REQ-014 Grant latency SHALL be 1 cycle: req sampled in IDLE at edge N -> gnt/busy valid after edge N.
REQ-015 In GRANT, gnt SHALL equal the 2-to-4 one-hot decode of gnt_id (00->0001, 01->0010, 10->0100, 11->1000); busy = 1.
REQ-016 SHALL keep an 8-bit hold counter, cleared on entry to GRANT, incremented each cycle in GRANT.
REQ-017 In GRANT, release SHALL occur when done = 1, or req[gnt_id] = 0, or counter = MAX_HOLD-1.
REQ-018 On release, SHALL return to IDLE, clear gnt and busy, set last = gnt_id; gnt_id holds.
REQ-019 timeout SHALL pulse 1 for the cycle after release only when the counter limit caused release and neither done nor req[gnt_id]=0 was present.
REQ-020 Minimum gap SHALL be one IDLE cycle between consecutive grants (no back-to-back grant).
REQ-021 done while in IDLE SHALL be ignored.
REQ-022 req bits other than gnt_id changing during GRANT SHALL have no effect on the grant.
REQ-023 Simultaneous done and counter limit SHALL count as normal release; timeout stays 0.
REQ-024 gnt SHALL never have more than one bit set in any cycle.
REQ-025 Counter SHALL not wrap; it cannot exceed MAX_HOLD-1.

Reset
REQ-026 While rst = 1 at a clock edge, SHALL enter IDLE, set gnt = 0000, gnt_id = 00, busy = 0, timeout = 0, counter = 0, last = 11.
REQ-027 Reset asserted in GRANT SHALL drop the grant after that edge with no timeout pulse; last returns to 11.
REQ-028 After reset release, first arbitration SHALL give requester 0 highest priority.

Verification
REQ-029 Reset then req=1111 held, done pulsed every 3rd GRANT cycle -> gnt sequence 0001,0010,0100,1000,0001, each separated by one 0000 cycle.
REQ-030 req=0100 at edge N in IDLE -> gnt=0100, gnt_id=10, busy=1 after edge N; done=1 at edge N+2 -> gnt=0000 after edge N+2, last=10.
REQ-031 req=0001 held, done never asserted, MAX_HOLD=8 -> gnt=0001 for exactly 8 cycles, then timeout=1 for one cycle with gnt=0000.
REQ-032 Grant to requester 3, then req[3] dropped -> gnt=0000 next cycle, timeout=0; pending req=0011 then grants 0001 (search from 0 after last=3).
REQ-033 rst=1 during GRANT of requester 2 -> after edge gnt=0000, gnt_id=00, busy=0; with req=1100 after reset, grant goes to 0100.
REQ-034 done and counter limit in same cycle -> release with timeout=0; done in IDLE -> no state change.
